// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: streams sequential fetches from a combinational program
// memory into a 2-entry FIFO for decode, with redirect flush and a retire counter.
module instr_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [15:0] retired_count
);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fq_entry_t;

    fq_entry_t   slot [2];
    logic [15:0] fetch_pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic        xfer;
    logic        push;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != 2'd0);
    assign xfer      = out_valid && out_ready;
    // A full queue can still accept a fetch when the head leaves in the same cycle.
    assign push      = !redirect_valid && ((count < 2'd2) || xfer);

    assign out_pc    = out_valid ? slot[head].pc    : 16'h0000;
    assign out_instr = out_valid ? slot[head].instr : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            count         <= 2'd0;
            head          <= 1'b0;
            tail          <= 1'b0;
            retired_count <= 16'h0000;
        end else begin
            // Decode already owns a word handed over in a redirect cycle, so it still retires.
            if (xfer)
                retired_count <= retired_count + 16'd1;
            if (redirect_valid) begin
                count    <= 2'd0;
                head     <= 1'b0;
                tail     <= 1'b0;
                fetch_pc <= redirect_pc;
            end else begin
                if (push) begin
                    slot[tail] <= '{pc: fetch_pc, instr: imem_instr};
                    tail       <= ~tail;
                    fetch_pc   <= fetch_pc + 16'd1;
                end
                if (xfer)
                    head <= ~head;
                count <= count + 2'(push) - 2'(xfer);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed checks of instr_fetch_queue plus a randomized run against a queue-based model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] retired_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Program memory: word = address XOR A000.
    assign imem_instr = imem_addr ^ 16'hA000;

    instr_fetch_queue #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .retired_count (retired_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] mq[$];
    logic [15:0] mpc;
    logic [15:0] mcnt;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_pc", out_pc, 16'h0000);
        chk("rst_instr", out_instr, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_retired", retired_count, 16'h0000);

        // Streaming with decode always ready
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", 16'(out_valid), 16'd1);
            chk("stream_pc", out_pc, 16'(i));
            chk("stream_instr", out_instr, 16'(i) ^ 16'hA000);
            chk("stream_retired", retired_count, 16'(i));
        end
        tick();
        chk("stream_retired4", retired_count, 16'd4);

        // Stall: queue fills to 2 and head holds
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", out_pc, 16'h0000);
            chk("stall_instr", out_instr, 16'hA000);
        end
        chk("stall_addr", imem_addr, 16'd2);
        chk("stall_retired", retired_count, 16'd0);
        out_ready = 1'b1;
        chk("drain_pc0", out_pc, 16'd0);
        tick();
        chk("drain_pc1", out_pc, 16'd1);
        tick();
        chk("drain_pc2", out_pc, 16'd2);
        chk("drain_retired", retired_count, 16'd2);

        // Redirect while full, with a transfer in the same cycle
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid0", 16'(out_valid), 16'd0);
        chk("redir_out_pc0", out_pc, 16'h0000);
        chk("redir_retired", retired_count, 16'd3);
        chk("redir_addr", imem_addr, 16'h0040);
        tick();
        chk("redir_valid1", 16'(out_valid), 16'd1);
        chk("redir_pc", out_pc, 16'h0040);
        chk("redir_instr", out_instr, 16'hA040);

        // Address wrap
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_retired", retired_count, 16'd4);
        tick(); chk("wrap_pc0", out_pc, 16'hFFFE);
        tick(); chk("wrap_pc1", out_pc, 16'hFFFF);
        tick(); chk("wrap_pc2", out_pc, 16'h0000);
        tick(); chk("wrap_pc3", out_pc, 16'h0001);

        // Reset beats redirect and handshake
        out_ready = 1'b0;
        tick(); tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h1234; out_ready = 1'b1;
        tick();
        chk("rstpri_valid", 16'(out_valid), 16'd0);
        chk("rstpri_retired", retired_count, 16'd0);
        chk("rstpri_addr", imem_addr, 16'h0000);
        rst = 1'b0; redirect_valid = 1'b0;
        tick();
        chk("rel_valid", 16'(out_valid), 16'd1);
        chk("rel_pc", out_pc, 16'h0000);

        // Randomized out_ready / redirect against a FIFO model
        rst = 1'b1; out_ready = 1'b0; tick();
        rst = 1'b0;
        mq.delete(); mpc = 16'h0000; mcnt = 16'h0000;
        for (int c = 0; c < 10000; c++) begin
            int  sz;
            logic xf;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            #1;
            sz = mq.size();
            chk("rnd_valid", 16'(out_valid), 16'(sz != 0));
            chk("rnd_pc", out_pc, (sz != 0) ? mq[0] : 16'h0000);
            chk("rnd_instr", out_instr, (sz != 0) ? (mq[0] ^ 16'hA000) : 16'h0000);
            chk("rnd_retired", retired_count, mcnt);
            chk("rnd_addr", imem_addr, mpc);
            xf = (sz != 0) && out_ready;
            if (xf) begin
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc;
            end else if (sz < 2 || xf) begin
                mq.push_back(mpc);
                mpc = mpc + 16'd1;
            end
            tick();
        end
        redirect_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
